// File: rtl/seg_scan_pkg.sv
// Shared types and width helpers for the seg_scan multiplexed 7-segment scan controller.
package seg_scan_pkg;

    localparam int NIB_W = 4;

    localparam int DEF_NUM_DIGITS   = 8;
    localparam int DEF_SCAN_DIV     = 1000;
    localparam int DEF_BLANK_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_SLOT_W  = cnt_w(DEF_SCAN_DIV);
    localparam int DEF_DIGIT_W = cnt_w(DEF_NUM_DIGITS);

endpackage

// File: rtl/seg_scan_slot_timer.sv
// Slot counter for seg_scan: free-runs 0..SCAN_DIV-1 while run_i is high and
// flags the last blanking cycle and the last cycle of each digit slot.
module scan_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic blank_end_o,
    output logic slot_end_o
);

    localparam int CW = cnt_w(SCAN_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign blank_end_o = (cnt_q == BLANK_CNT);
    assign slot_end_o  = (cnt_q == LAST_CNT);

    // Held at zero when not running so every start begins a fresh slot.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i)          cnt_d = '0;
        else if (slot_end_o) cnt_d = '0;
        else                 cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed N-digit 7-segment scan controller with per-slot blanking and
// frame-coherent capture. Optional leading-zero blanking: SEG_SCAN_LZ_BLANK_EN.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NIB_W*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    output logic [NIB_W-1:0]            hex_data,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       digit_sel,
    output logic                        frame_done
);

    localparam int DW = cnt_w(NUM_DIGITS);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    scan_state_e state_q, state_d;
    logic [DW-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0][NIB_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

    logic [NIB_W-1:0]      hex_q, hex_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fd_q, fd_d;

    logic blank_end, slot_end, run;
    logic [NUM_DIGITS-1:0] show;

    assign run = en && (state_q != IDLE);

    scan_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run),
        .blank_end_o (blank_end),
        .slot_end_o  (slot_end)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit stays lit if it or any more significant digit is nonzero, or it carries a dp.
    always_comb begin
        logic hi_nz;
        hi_nz = 1'b0;
        show  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_nz   = hi_nz | (|shadow_q[k]);
            show[k] = (k == 0) || hi_nz || shadow_dp_q[k];
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    idx_d       = '0;
                    shadow_d    = data_in;
                    shadow_dp_d = dp_in;
                end
                BLANK: if (blank_end) state_d = DRIVE;
                DRIVE: if (slot_end) begin
                    state_d = BLANK;
                    if (idx_q == LAST_DIGIT) begin
                        idx_d       = '0;
                        shadow_d    = data_in;
                        shadow_dp_d = dp_in;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs reflect the current state one cycle later; en=0 darkens them on the same edge.
    always_comb begin
        hex_d = '0;
        dp_d  = 1'b0;
        sel_d = '0;
        fd_d  = 1'b0;
        if (run) begin
            hex_d = shadow_q[idx_q];
            if (state_q == DRIVE && show[idx_q]) begin
                sel_d[idx_q] = 1'b1;
                dp_d         = shadow_dp_q[idx_q];
            end
            fd_d = (state_q == DRIVE) && slot_end && (idx_q == LAST_DIGIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            hex_q       <= '0;
            dp_q        <= 1'b0;
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    assign hex_data   = hex_q;
    assign dp_out     = dp_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  hex_data;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    seg_scan #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .hex_data   (hex_data),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_sel"}, 32'(digit_sel), 32'h0);
        chk({tag, "_hex"}, 32'(hex_data), 32'h0);
        chk({tag, "_dp"}, 32'(dp_out), 32'h0);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    // e = number of edges since the edge that sampled en=1 (that edge is e=0).
    task automatic check_scan(input int e, input logic [15:0] w, input logic [3:0] dpv);
        int t, slot;
        logic drive, show, xdp;
        logic [3:0] xsel, xhex;
        t     = e - 1;
        slot  = (t / 8) % 4;
        drive = (t % 8) >= 2;
        show  = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
        show = (slot == 0) || dpv[slot] || ((w >> (slot * 4)) != 16'h0);
`endif
        xsel = 4'b0;
        if (drive && show) xsel[slot] = 1'b1;
        xhex = w[slot*4 +: 4];
        xdp  = drive && show && dpv[slot];
        chk($sformatf("sel_e%0d", e), 32'(digit_sel), 32'(xsel));
        chk($sformatf("hex_e%0d", e), 32'(hex_data), 32'(xhex));
        chk($sformatf("dp_e%0d", e), 32'(dp_out), 32'(xdp));
        chk($sformatf("fd_e%0d", e), 32'(frame_done), 32'((e % 32) == 0));
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        data_in = 16'h0;
        dp_in   = 4'h0;
        #12;
        chk_dark("reset");
        rst_n = 1'b1;
        repeat (3) step();
        chk_dark("idle_wait");

        // Scan order, dp, and frame-coherent capture across two frames into a third.
        data_in = 16'h1234;
        dp_in   = 4'b0100;
        en      = 1'b1;
        step();
        chk_dark("start_edge");
        for (int e = 1; e <= 85; e++) begin
            step();
            check_scan(e, (e <= 32) ? 16'h1234 : 16'hABCD, 4'b0100);
            if (e == 20) data_in = 16'hABCD;
        end

        // e=85 is mid-DRIVE of digit 2; dropping en darkens on the next edge.
        en = 1'b0;
        step();
        chk_dark("disable");
        repeat (2) step();
        chk_dark("disabled_hold");

        en = 1'b1;
        step();
        chk_dark("reenable_edge");
        for (int e = 1; e <= 5; e++) begin
            step();
            check_scan(e, 16'hABCD, 4'b0100);
        end

        // Asynchronous reset mid-DRIVE, observed before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_dark("async_rst");
        en = 1'b0;
        repeat (2) step();
        chk_dark("rst_held");
        rst_n = 1'b1;
        repeat (2) step();
        chk_dark("post_rst_wait");

        // Leading-zero case.
        data_in = 16'h0050;
        dp_in   = 4'b0000;
        en      = 1'b1;
        step();
        chk_dark("lz_start_edge");
        for (int e = 1; e <= 33; e++) begin
            step();
            check_scan(e, 16'h0050, 4'b0000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scan controller for an N-digit common-bus 7-segment display.
- Sits directly upstream of the hex-to-7-segment decoder: drives the 4-bit hex nibble of the currently selected digit onto the decoder input and a one-hot digit enable to the display.
- Inserts a blanking gap between digits to suppress ghosting.
- Captures the display value once per frame so a digit never tears mid-frame.

Parameters:
- NUM_DIGITS, 8, number of display digits (2..16).
- SCAN_DIV, 1000, clock cycles per digit slot, including blanking.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off; constraint 1 <= BLANK_CYCLES < SCAN_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = display dark.
- data_in  in  4*NUM_DIGITS  packed nibbles; digit k = data_in[4k+3:4k]; digit 0 = rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- hex_data  out  4  nibble for the downstream hex-to-7-segment decoder.
- dp_out  out  1  decimal point of the current digit, gated by digit enable.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark.
- frame_done  out  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs registered. rst_n=0 asynchronously forces hex_data=0, dp_out=0, digit_sel=0, frame_done=0, state IDLE, slot counter 0, digit index 0, shadow register 0.
- States:
  - IDLE: entered at reset. Outputs as at reset.
  - IDLE -> BLANK: on a clk edge with en=1. Same edge: shadow <= data_in and dp_in, digit index <= 0, slot counter <= 0.
  - BLANK: digit_sel=0, dp_out=0. hex_data is already the nibble of the current digit, so the decoder settles before enable. Lasts exactly BLANK_CYCLES clocks, then -> DRIVE.
  - DRIVE: digit_sel has bit [digit index] set; dp_out = shadow dp of that digit. Lasts SCAN_DIV-BLANK_CYCLES clocks.
  - At the end of DRIVE: digit index increments and the FSM returns to BLANK.
  - Wrap from NUM_DIGITS-1 to 0: same edge reloads shadow from data_in/dp_in and sets frame_done=1 for exactly one cycle.
- Frame period: NUM_DIGITS*SCAN_DIV clocks.
- Disable: en=0 sampled in any state -> IDLE on that edge; outputs dark the following cycle. Re-enable always restarts at digit 0 with a fresh capture.
- Input changes: data_in/dp_in changes mid-frame have no visible effect until the next wrap.
- Counter widths: slot counter width = clog2(SCAN_DIV); digit index width = clog2(NUM_DIGITS). No counter may exceed its terminal value.
- Digit gating: digit_sel is never multi-hot. digit_sel is never nonzero in BLANK or IDLE.
- Reset mid-operation: immediate dark outputs. After release, waits for en exactly as from power-up.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined: during DRIVE, digit k (k>0) keeps digit_sel=0 when its shadow nibble and all higher nibbles are zero and its shadow dp is 0. Digit 0 is always shown. Slot timing is unchanged.
- Undefined: every digit is driven regardless of value.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum (IDLE, BLANK, DRIVE)
  - width helper constants derived from NUM_DIGITS/SCAN_DIV
  - nibble width constant 4
- Sub-module scan_slot_timer: the SCAN_DIV slot counter producing blank_end and slot_end strobes. The FSM and digit indexing stay in seg_scan.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2):
- Reset: assert rst_n=0 mid-DRIVE between clock edges -> digit_sel=0000, hex_data=0, frame_done=0 without waiting for a clk edge; held until en is seen after release.
- Scan order: data_in=16'h1234, en=1 at edge E0 -> edges E1..E2 digit_sel=0000 and hex_data=4; E3..E8 digit_sel=0001, hex_data=4. Subsequent digits show 3/0010, 2/0100, 1/1000. frame_done=1 only in the cycle after E32; the pattern then repeats.
- Frame-coherent capture: change data_in to 16'hABCD during digit 2 -> remaining slots of that frame still show 2,1; the next frame shows D,C,B,A.
- Disable/re-enable: en=0 mid-DRIVE of digit 2 -> next cycle digit_sel=0000, state IDLE. en=1 again -> restart at digit 0 with BLANK first.
- Decimal point: dp_in=4'b0100 -> dp_out=1 only during DRIVE of digit 2; 0 during every BLANK.
- Leading-zero blanking: data_in=16'h0050, macro defined -> digit_sel stays 0000 in slots 3 and 2; slot 1 shows 5, slot 0 shows 0. Macro undefined -> all four slots enabled.
